// File: rtl/qam_symbol_mapper.sv
// qam_symbol_mapper
// Maps 4-bit right-aligned bit groups to signed Gray-coded I/Q amplitudes
// (QPSK or 16QAM, selectable per symbol) and buffers the mapped pairs in a
// small first-word-fall-through FIFO with a valid/ready output handshake.
// Overruns are latched in a sticky flag; popped symbols are counted.
module qam_symbol_mapper #(
  parameter int OUT_W      = 12,
  parameter int AMP_UNIT   = 512,
  parameter int AMP_QPSK   = 1145,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mod_type,
  input  logic             sym_valid,
  input  logic [3:0]       sym_bits,
  output logic             sym_ready,
  output logic [OUT_W-1:0] i_out,
  output logic [OUT_W-1:0] q_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow_err,
  output logic [15:0]      sym_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int PROD_W = OUT_W + 2;

  localparam logic signed [PROD_W-1:0] UNIT_P  = PROD_W'(AMP_UNIT);
  localparam logic signed [PROD_W-1:0] UNIT3_P = PROD_W'(3 * AMP_UNIT);
  localparam logic signed [PROD_W-1:0] QPSK_P  = PROD_W'(AMP_QPSK);
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(1 << (OUT_W - 1)));
  localparam logic [PTR_W:0]           PTR_ONE = (PTR_W + 1)'(1);

  // Gray-coded 16QAM level for one axis: 00 -3U, 01 -1U, 11 +1U, 10 +3U.
  function automatic logic signed [PROD_W-1:0] gray_level(input logic [1:0] b);
    logic signed [PROD_W-1:0] lvl;
    case (b)
      2'b00:   lvl = -UNIT3_P;
      2'b01:   lvl = -UNIT_P;
      2'b11:   lvl = UNIT_P;
      default: lvl = UNIT3_P;
    endcase
    return lvl;
  endfunction

  // QPSK level for one axis: 0 -> -A, 1 -> +A.
  function automatic logic signed [PROD_W-1:0] qpsk_level(input logic b);
    return b ? QPSK_P : -QPSK_P;
  endfunction

  // Clamp a wide amplitude into the signed OUT_W output range.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [PROD_W-1:0] x);
    logic signed [OUT_W-1:0] y;
    if (x > SAT_MAX)
      y = SAT_MAX[OUT_W-1:0];
    else if (x < SAT_MIN)
      y = SAT_MIN[OUT_W-1:0];
    else
      y = x[OUT_W-1:0];
    return y;
  endfunction

  // ---- Stage p0: combinational mapping of the incoming bit group ----
  logic signed [PROD_W-1:0] i_prod_p0;
  logic signed [PROD_W-1:0] q_prod_p0;
  logic signed [OUT_W-1:0]  i_map_p0;
  logic signed [OUT_W-1:0]  q_map_p0;

  // Select the constellation for this symbol; QPSK ignores bits[3:2].
  always_comb begin
    i_prod_p0 = '0;
    q_prod_p0 = '0;
    if (mod_type) begin
      i_prod_p0 = gray_level(sym_bits[3:2]);
      q_prod_p0 = gray_level(sym_bits[1:0]);
    end else begin
      i_prod_p0 = qpsk_level(sym_bits[1]);
      q_prod_p0 = qpsk_level(sym_bits[0]);
    end
  end

  assign i_map_p0 = sat_out(i_prod_p0);
  assign q_map_p0 = sat_out(q_prod_p0);

  // ---- Stage p1: FIFO storage of already-mapped I/Q pairs ----
  logic signed [OUT_W-1:0] mem_i_p1 [FIFO_DEPTH];
  logic signed [OUT_W-1:0] mem_q_p1 [FIFO_DEPTH];
  logic [PTR_W:0]          wr_ptr;
  logic [PTR_W:0]          rd_ptr;
  logic                    empty;
  logic                    full;
  logic                    push_p0;
  logic                    pop_p1;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                   (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign push_p0 = sym_valid && !full;
  assign pop_p1  = !empty && out_ready;

  // Data storage is not reset; an entry is only visible once the write pointer passes it.
  always_ff @(posedge clk) begin
    if (push_p0) begin
      mem_i_p1[wr_ptr[PTR_W-1:0]] <= i_map_p0;
      mem_q_p1[wr_ptr[PTR_W-1:0]] <= q_map_p0;
    end
  end

  // Pointer, overrun and pop-count control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow_err <= 1'b0;
      sym_count    <= '0;
    end else begin
      if (push_p0)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_p1) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        sym_count <= sym_count + 16'd1;
      end
      if (sym_valid && full)
        overflow_err <= 1'b1;
    end
  end

  // ---- Output: head entry falls through, forced to zero when empty ----
  assign sym_ready = !full;
  assign out_valid = !empty;
  assign i_out     = empty ? '0 : mem_i_p1[rd_ptr[PTR_W-1:0]];
  assign q_out     = empty ? '0 : mem_q_p1[rd_ptr[PTR_W-1:0]];

endmodule
